// File: rtl/parity_pkg.sv
// Shared constants and types for the parity checker slice.
// Default widths live here so the interface and all modules agree on them.
package parity_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_CNT_W  = 16;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  // Turns a raw XOR reduction into the parity bit for the selected mode.
  function automatic logic apply_mode(input logic xor_red, input parity_mode_e mode);
    return xor_red ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/parity_checker_if.sv
// Word stream, parity results and error-status signals of the parity checker.
// Handshake: a word transfers on every rising clk edge where in_valid=1; there is
// no ready, so the checker accepts every cycle, and out_valid=1 marks one result.
interface parity_checker_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
);

  logic              in_valid;
  logic [DATA_W-1:0] data;
  logic              parity_in;
  logic              odd_mode;
  logic              clr_err;
  logic              out_valid;
  logic              parity_out;
  logic              error;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, data, parity_in, odd_mode, clr_err,
    input  out_valid, parity_out, error, err_sticky, err_count
  );

  modport slave (
    input  in_valid, data, parity_in, odd_mode, clr_err,
    output out_valid, parity_out, error, err_sticky, err_count
  );

endinterface

// File: rtl/parity_tree.sv
// Stateless XOR reduction of a data word.
module parity_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_checker.sv
// Registered parity generator/checker: one-cycle latency, no backpressure,
// sticky error flag and saturating errored-word counter.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input logic             clk,
  input logic             rst,
  parity_checker_if.slave bus
);

  logic             xor_red;
  logic             gen_parity;
  logic             word_err;
  logic             out_valid_q;
  logic             parity_out_q;
  logic             error_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] err_count_q;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data   (bus.data),
    .parity (xor_red)
  );

  assign gen_parity = apply_mode(xor_red, parity_mode_e'(bus.odd_mode));
  assign word_err   = bus.in_valid & (bus.parity_in ^ gen_parity);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      parity_out_q <= 1'b0;
      error_q      <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        parity_out_q <= gen_parity;
        error_q      <= bus.parity_in ^ gen_parity;
      end
      // A clear wipes old status first; an error arriving with it still counts.
      if (bus.clr_err) begin
        err_sticky_q <= word_err;
        err_count_q  <= word_err ? CNT_W'(1) : '0;
      end else if (word_err) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.parity_out = parity_out_q;
  assign bus.error      = error_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_parity_checker.sv
// Directed plus random stimulus for parity_checker with a queued expected-result model.
module tb_parity_checker;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int EXP_W  = 3 + 1 + CNT_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  logic             m_po, m_err, m_st;
  logic [CNT_W-1:0] m_cnt;

  parity_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic [EXP_W-1:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_out_valid"},  CNT_W'(bus.out_valid),  CNT_W'(e[EXP_W-1]));
    chk({tag, "_parity_out"}, CNT_W'(bus.parity_out), CNT_W'(e[EXP_W-2]));
    chk({tag, "_error"},      CNT_W'(bus.error),      CNT_W'(e[EXP_W-3]));
    chk({tag, "_err_sticky"}, CNT_W'(bus.err_sticky), CNT_W'(e[CNT_W]));
    chk({tag, "_err_count"},  bus.err_count,          e[CNT_W-1:0]);
  endtask

  task automatic step(input string tag, input logic iv, input logic [DATA_W-1:0] d,
                      input logic p, input logic odd, input logic clr);
    logic gen, new_err;
    bus.in_valid  = iv;
    bus.data      = d;
    bus.parity_in = p;
    bus.odd_mode  = odd;
    bus.clr_err   = clr;
    // Reference: even parity makes total ones even, odd mode inverts.
    gen = (^d) ^ odd;
    new_err = iv && (p != gen);
    if (iv) begin
      m_po  = gen;
      m_err = p ^ gen;
    end
    if (clr) begin
      m_st  = new_err;
      m_cnt = new_err ? CNT_W'(1) : '0;
    end else if (new_err) begin
      m_st = 1'b1;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    exp_q.push_back({iv, m_po, m_err, m_st, m_cnt});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic reset_cycle(input string tag, input logic iv, input logic [DATA_W-1:0] d);
    rst           = 1'b1;
    bus.in_valid  = iv;
    bus.data      = d;
    bus.parity_in = 1'b1;
    bus.odd_mode  = 1'b0;
    bus.clr_err   = 1'b1;
    m_po = 1'b0; m_err = 1'b0; m_st = 1'b0; m_cnt = '0;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    check_out(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.data = '0; bus.parity_in = 1'b0;
    bus.odd_mode = 1'b0; bus.clr_err = 1'b0;
    @(posedge clk);
    reset_cycle("reset", 1'b0, 4'b0000);

    step("w1101",   1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
    step("w1010",   1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    step("w0000",   1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("w1111",   1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step("idle",    1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    step("clr",     1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step("odd_ok",  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("odd_bad", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("clr2",    1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) step("sat", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step("clr_err_same", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0));

    step("pre_rst", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    reset_cycle("mid_rst", 1'b1, 4'b0001);
    step("post_rst", 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
    step("post_rst_idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 Parameter: DATA_W, default 4, data word width in bits; legal range 1..64.
REQ-002 Parameter: CNT_W, default 16, width of the error counter.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: in_valid  input  1  qualifies data and parity_in this cycle.
REQ-006 Port: data  input  DATA_W  word to be protected or checked.
REQ-007 Port: parity_in  input  1  received parity bit for data.
REQ-008 Port: odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with in_valid.
REQ-009 Port: clr_err  input  1  clears the sticky flag and the error counter.
REQ-010 Port: out_valid  output  1  result registers updated from an accepted word.
REQ-011 Port: parity_out  output  1  generated parity of the accepted data.
REQ-012 Port: error  output  1  parity_in disagrees with the generated parity.
REQ-013 Port: err_sticky  output  1  set by any error and held until cleared.
REQ-014 Port: err_count  output  CNT_W  number of errored words, saturating.

Function
REQ-015 Generated parity SHALL be the XOR of all data bits, inverted when odd_mode=1, so the result makes the total count of ones even (or odd) including the parity bit.
REQ-016 error SHALL equal parity_in XOR generated parity.
REQ-017 Latency SHALL be exactly one cycle: a word accepted with in_valid=1 at edge N gives out_valid=1, parity_out and error after edge N.
REQ-018 When in_valid=0, out_valid SHALL be 0 on the next cycle. parity_out and error SHALL hold their last values.
REQ-019 Back-to-back words SHALL be accepted every cycle, with no stall and no backpressure.
REQ-020 err_sticky SHALL be set on the cycle in which error is registered as 1 with out_valid=1.
REQ-021 err_count SHALL increment by 1 per errored word and saturate at all-ones without wrapping.
REQ-022 clr_err=1 SHALL zero err_sticky and err_count on the next edge.
REQ-023 If clr_err and an errored word arrive in the same cycle, the clear SHALL apply first and the new error SHALL count. Result: err_sticky=1, err_count=1.
REQ-024 clr_err SHALL NOT affect out_valid, parity_out or error.

Reset
REQ-025 With rst=1 at a rising edge, the following SHALL all be 0: out_valid, parity_out, error, err_sticky, err_count.
REQ-026 rst SHALL take priority over in_valid and clr_err. A word presented during reset SHALL be discarded.
REQ-027 The first word accepted after rst deasserts SHALL behave as in REQ-017.

Structure
REQ-028 Package parity_pkg SHALL hold the default DATA_W and CNT_W constants.
REQ-029 Package parity_pkg SHALL hold a parity_mode_e typedef with values EVEN=0 and ODD=1.
REQ-030 Combinational parity generation SHALL be a sub-module parity_tree: input data[DATA_W-1:0], output XOR reduction, no state.
REQ-031 All registers SHALL reside in parity_checker. There SHALL be no latches and no combinational path from inputs to outputs.

Verification
REQ-032 Accept data=1101, parity_in=1, odd_mode=0 -> next cycle out_valid=1, parity_out=1, error=0.
REQ-033 Accept data=1010, parity_in=0, then 0000/0, then 1111/1, all even mode:
- 1010/0 -> parity_out=0, error=0.
- 0000/0 -> parity_out=0, error=0.
- 1111/1 -> parity_out=0, error=1, err_sticky=1, err_count=1.
REQ-034 Odd mode: data=0000, parity_in=1, odd_mode=1 -> parity_out=1, error=0. Repeat with parity_in=0 -> error=1.
REQ-035 Counter behaviour, CNT_W=2:
- Four consecutive errored words -> err_count=3 (saturated).
- Then clr_err together with an errored word -> err_count=1, err_sticky=1.
REQ-036 Assert rst mid-stream with in_valid=1 -> all outputs 0 on the next cycle. After release, the next word completes with latency 1.
